// File: rtl/demux3_stream_pkg.sv
// Shared CPU types: default word width, result destination tags and the
// select-priority decode used by both the select mux and this demux.
package rvcpu;

  localparam int Width = 32;

  typedef enum logic [1:0] {
    DEST_A = 2'd0,
    DEST_B = 2'd1,
    DEST_C = 2'd2
  } dest_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } slot_state_e;

  // sel_a dominates sel_b so every select user agrees on priority
  function automatic dest_e decode_dest(input logic sel_a, input logic sel_b);
    dest_e d;
    if (sel_a)      d = DEST_A;
    else if (sel_b) d = DEST_B;
    else            d = DEST_C;
    return d;
  endfunction

endpackage

// File: rtl/demux3_stream_reg.sv
// One-entry valid/ready register slice with synchronous flush; out_data
// holds its last loaded value and resets to RESET_VAL.
module stream_reg
  import rvcpu::*;
#(
  parameter int           W         = 8,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  slot_state_e  r_state;
  slot_state_e  w_stateNext;
  logic         w_load;
  logic [W-1:0] r_data;

  always_comb begin
    w_stateNext = r_state;
    in_ready    = 1'b0;
    case (r_state)
      ST_EMPTY: in_ready = !flush;
      ST_FULL:  in_ready = !flush && out_ready;
      default:  in_ready = 1'b0;
    endcase
    w_load = in_valid && in_ready;
    // flush wins over everything, including a simultaneous handshake
    if (flush)
      w_stateNext = ST_EMPTY;
    else if (w_load)
      w_stateNext = ST_FULL;
    else if (r_state == ST_FULL && out_ready)
      w_stateNext = ST_EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_stateNext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_data <= RESET_VAL;
    else if (w_load) r_data <= in_data;
  end

  assign out_valid = (r_state == ST_FULL);
  assign out_data  = r_data;

endmodule

// File: rtl/demux3_stream.sv
// Registered one-to-three stream demux. Define DEMUX3_SKID_EN to add a skid
// entry behind the holding stage so in_ready no longer depends on out_*_ready.
module demux3_stream
  import rvcpu::*;
#(
  parameter int Width = rvcpu::Width
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel_a,
  input  logic             in_sel_b,
  input  logic [Width-1:0] in_data,
  output logic             out_a_valid,
  output logic             out_b_valid,
  output logic             out_c_valid,
  input  logic             out_a_ready,
  input  logic             out_b_ready,
  input  logic             out_c_ready,
  output logic [Width-1:0] out_data
);

  localparam int PW = Width + 2;
  localparam logic [PW-1:0] ResetPayload = {DEST_C, {Width{1'b0}}};

  logic          w_holdValid;
  logic [PW-1:0] w_holdData;
  logic [PW-1:0] w_newPayload;
  dest_e         w_tag;
  logic          w_selReady;

  assign w_newPayload = {decode_dest(in_sel_a, in_sel_b), in_data};
  assign w_tag        = dest_e'(w_holdData[PW-1:Width]);

  always_comb begin
    w_selReady = 1'b0;
    case (w_tag)
      DEST_A:  w_selReady = out_a_ready;
      DEST_B:  w_selReady = out_b_ready;
      DEST_C:  w_selReady = out_c_ready;
      default: w_selReady = 1'b0;
    endcase
  end

`ifdef DEMUX3_SKID_EN
  logic          w_skidValid;
  logic          w_skidInReady;
  logic [PW-1:0] w_skidData;
  logic          w_holdInReady;
  logic          w_accept;

  assign in_ready = !w_skidValid && !flush;
  assign w_accept = in_valid && in_ready;

  // the skid only fills when the holding stage cannot take the word now
  stream_reg #(.W(PW), .RESET_VAL(ResetPayload)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (w_accept && !w_holdInReady && w_skidInReady),
    .in_ready  (w_skidInReady),
    .in_data   (w_newPayload),
    .out_valid (w_skidValid),
    .out_ready (w_holdInReady),
    .out_data  (w_skidData)
  );

  stream_reg #(.W(PW), .RESET_VAL(ResetPayload)) u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (w_skidValid || w_accept),
    .in_ready  (w_holdInReady),
    .in_data   (w_skidValid ? w_skidData : w_newPayload),
    .out_valid (w_holdValid),
    .out_ready (w_selReady),
    .out_data  (w_holdData)
  );
`else
  stream_reg #(.W(PW), .RESET_VAL(ResetPayload)) u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_newPayload),
    .out_valid (w_holdValid),
    .out_ready (w_selReady),
    .out_data  (w_holdData)
  );
`endif

  assign out_a_valid = w_holdValid && (w_tag == DEST_A);
  assign out_b_valid = w_holdValid && (w_tag == DEST_B);
  assign out_c_valid = w_holdValid && (w_tag == DEST_C);
  assign out_data    = w_holdData[Width-1:0];

endmodule

// File: tb/tb_demux3_stream.sv
// Self-checking bench for demux3_stream (base build): directed scenarios plus
// random traffic compared against a one-deep FIFO reference model.
module tb_demux3_stream;

  localparam int W = rvcpu::Width;

  typedef struct {
    int           dest;
    logic [W-1:0] data;
  } item_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         in_sel_a = 1'b0;
  logic         in_sel_b = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_a_valid, out_b_valid, out_c_valid;
  logic [2:0]   rdy = 3'b111;
  logic [W-1:0] out_data;

  int    checks = 0;
  int    errors = 0;
  item_t q[$];

  always #5 clk = ~clk;

  demux3_stream #(.Width(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sel_a    (in_sel_a),
    .in_sel_b    (in_sel_b),
    .in_data     (in_data),
    .out_a_valid (out_a_valid),
    .out_b_valid (out_b_valid),
    .out_c_valid (out_c_valid),
    .out_a_ready (rdy[0]),
    .out_b_ready (rdy[1]),
    .out_c_ready (rdy[2]),
    .out_data    (out_data)
  );

  // Reference: capacity-one FIFO, destination from the select priority rule
  function automatic int routeOf(input logic sa, input logic sb);
    return sa ? 0 : (sb ? 1 : 2);
  endfunction

  function automatic logic [2:0] expValids();
    if (q.size() == 0) return 3'b000;
    return 3'(1 << q[0].dest);
  endfunction

  function automatic logic expReady();
    if (flush) return 1'b0;
    if (q.size() == 0) return 1'b1;
    return rdy[q[0].dest];
  endfunction

  function automatic logic [2:0] obsValids();
    return {out_c_valid, out_b_valid, out_a_valid};
  endfunction

  task automatic applyStimulus(input logic v, input logic sa, input logic sb,
                               input logic [W-1:0] d, input logic [2:0] r,
                               input logic fl);
    in_valid = v; in_sel_a = sa; in_sel_b = sb; in_data = d; rdy = r; flush = fl;
  endtask

  // Advance one clock edge and move the reference model with it
  task automatic advance();
    logic  willPop, willPush;
    item_t it;
    willPop  = (q.size() != 0) && rdy[q[0].dest];
    willPush = in_valid && expReady();
    it.dest  = routeOf(in_sel_a, in_sel_b);
    it.data  = in_data;
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (willPop) void'(q.pop_front());
      if (willPush) q.push_back(it);
    end
    #1;
  endtask

  task automatic test_reset();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 3'b111, 1'b0);
    rst_n = 1'b0;
    #12;
    checks++;
    if (obsValids() !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_valids: got %b want 000", obsValids());
    end
    checks++;
    if (out_data !== '0) begin
      errors++; $display("[TB] FAIL reset_data: got %h want 0", out_data);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic test_routing();
    logic [W-1:0] words [3];
    logic [2:0]   wantV [3];
    words[0] = W'('h11); words[1] = W'('h22); words[2] = W'('h33);
    wantV[0] = 3'b001;   wantV[1] = 3'b010;   wantV[2] = 3'b100;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) applyStimulus(1'b1, i == 0, i == 1, words[i], 3'b111, 1'b0);
      else       applyStimulus(1'b0, 1'b0, 1'b0, '0, 3'b111, 1'b0);
      @(negedge clk);
      checks++;
      if (obsValids() !== (i == 0 ? 3'b000 : wantV[i-1])) begin
        errors++; $display("[TB] FAIL routing_valid[%0d]: got %b want %b", i, obsValids(),
                           i == 0 ? 3'b000 : wantV[i-1]);
      end
      if (i > 0) begin
        checks++;
        if (out_data !== words[i-1]) begin
          errors++; $display("[TB] FAIL routing_data[%0d]: got %h want %h", i, out_data, words[i-1]);
        end
      end
      advance();
    end
  endtask

  task automatic test_priority();
    applyStimulus(1'b1, 1'b1, 1'b1, W'('hAA), 3'b111, 1'b0);
    advance();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 3'b111, 1'b0);
    @(negedge clk);
    checks++;
    if (obsValids() !== 3'b001 || out_data !== W'('hAA)) begin
      errors++; $display("[TB] FAIL priority: got valids %b data %h want 001 aa", obsValids(), out_data);
    end
    advance();
  endtask

  task automatic test_backpressure();
    applyStimulus(1'b1, 1'b0, 1'b1, W'('h55), 3'b101, 1'b0);
    advance();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'($urandom), 1'($urandom), W'($urandom), 3'b101, 1'b0);
      @(negedge clk);
      checks++;
      if (obsValids() !== 3'b010 || out_data !== W'('h55) || in_ready !== 1'b0) begin
        errors++; $display("[TB] FAIL backpressure[%0d]: valids %b data %h ready %b want 010 55 0",
                           i, obsValids(), out_data, in_ready);
      end
      advance();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 3'b111, 1'b0);
    @(negedge clk);
    checks++;
    if (obsValids() !== 3'b010 || out_data !== W'('h55)) begin
      errors++; $display("[TB] FAIL backpressure_release: valids %b data %h want 010 55", obsValids(), out_data);
    end
    advance();
    @(negedge clk);
    checks++;
    if (obsValids() !== 3'b000) begin
      errors++; $display("[TB] FAIL backpressure_drain: valids %b want 000", obsValids());
    end
    advance();
  endtask

  task automatic test_streaming();
    int handshakes = 0;
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) applyStimulus(1'b1, (i % 3) == 0, (i % 3) == 1, W'(i), 3'b111, 1'b0);
      else        applyStimulus(1'b0, 1'b0, 1'b0, '0, 3'b111, 1'b0);
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (obsValids() !== 3'(1 << ((i - 1) % 3)) || out_data !== W'(i - 1)) begin
          errors++; $display("[TB] FAIL stream[%0d]: valids %b data %h want %b %h", i - 1,
                             obsValids(), out_data, 3'(1 << ((i - 1) % 3)), W'(i - 1));
        end
        if ((obsValids() & rdy) != 3'b000) handshakes++;
      end
      if (i < 16) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++; $display("[TB] FAIL stream_ready[%0d]: got %b want 1", i, in_ready);
        end
      end
      advance();
    end
    checks++;
    if (handshakes != 16) begin
      errors++; $display("[TB] FAIL stream_handshakes: got %0d want 16", handshakes);
    end
  endtask

  task automatic test_flush();
    applyStimulus(1'b1, 1'b0, 1'b0, W'('h99), 3'b011, 1'b0);
    advance();
    applyStimulus(1'b1, 1'b0, 1'b0, W'('h77), 3'b011, 1'b1);
    @(negedge clk);
    checks++;
    if (obsValids() !== 3'b100 || in_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL flush_cycle: valids %b ready %b want 100 0", obsValids(), in_ready);
    end
    advance();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 3'b111, 1'b0);
      @(negedge clk);
      checks++;
      if (obsValids() !== 3'b000 || in_ready !== 1'b1) begin
        errors++; $display("[TB] FAIL flush_after[%0d]: valids %b ready %b want 000 1", i, obsValids(), in_ready);
      end
      advance();
    end
  endtask

  task automatic test_async_reset();
    applyStimulus(1'b1, 1'b1, 1'b0, W'('h3C), 3'b110, 1'b0);
    advance();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 3'b110, 1'b0);
    @(negedge clk);
    checks++;
    if (obsValids() !== 3'b001) begin
      errors++; $display("[TB] FAIL areset_pre: valids %b want 001", obsValids());
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (obsValids() !== 3'b000 || out_data !== '0 || in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL areset_now: valids %b data %h ready %b want 000 0 1",
                         obsValids(), out_data, in_ready);
    end
    #1 rst_n = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 3'b111, 1'b0);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || obsValids() !== 3'b000) begin
      errors++; $display("[TB] FAIL areset_after: ready %b valids %b want 1 000", in_ready, obsValids());
    end
    advance();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), W'($urandom),
                    3'($urandom), $urandom_range(0, 15) == 0);
      @(negedge clk);
      checks++;
      if (obsValids() !== expValids()) begin
        errors++; $display("[TB] FAIL random_valid[%0d]: got %b want %b", i, obsValids(), expValids());
      end
      checks++;
      if (in_ready !== expReady()) begin
        errors++; $display("[TB] FAIL random_ready[%0d]: got %b want %b", i, in_ready, expReady());
      end
      if (q.size() != 0) begin
        checks++;
        if (out_data !== q[0].data) begin
          errors++; $display("[TB] FAIL random_data[%0d]: got %h want %h", i, out_data, q[0].data);
        end
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_routing();
    test_priority();
    test_backpressure();
    test_streaming();
    test_flush();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
